serial_add16_ctrl: RTL and testbench
====================================

# serial_add16_ctrl

Multi-cycle 16-bit adder controller that time-shares a single 4-bit carry-lookahead nibble slice across four cycles to produce saturating ADD, SUB and (optionally) PADDSB results for the ALU. It accepts one operation per start/done handshake. Between cycles it carries the nibble carry from the slice's group generate/propagate outputs. It also produces Z/V/N flags for the flag register. It sits between ALU decode and the writeback mux in area-reduced builds.

## Interface
- No parameters; widths come from the package (WORD_W=16, NIB_W=4).
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when ready=1
- op  in  2  operation: 00 ADD, 01 SUB, 10 PADDSB, 11 reserved (executes as ADD)
- a  in  16  operand A, captured on accepted start
- b  in  16  operand B, captured on accepted start
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse; result and flags valid
- result  out  16  result; holds until the next done
- z  out  1  result==0, updated with done
- v  out  1  signed overflow/saturation occurred, updated with done
- n  out  1  result[15], updated with done

## Operation
- States: IDLE, CALC, DONE. A 2-bit nibble index idx is valid in CALC.
- IDLE: ready=1. If start=1, latch a, op, and b (inverted when op=SUB). Set carry to 1 for SUB, else 0. Set idx=0 and go to CALC.
- CALC, each cycle:
  - Slice adds a_q[idx], b_q[idx] and carry.
  - Nibble carry-out = gen | (prop & carry), registered into carry.
  - Sum nibble written to result_q[idx].
  - idx increments.
  - After idx=3, go to DONE.
- ADD/SUB saturation:
  - Overflow = carry into MSB nibble's bit 3 XOR carry-out of bit 3, evaluated in the idx=3 cycle.
  - On overflow, the entire result_q is replaced in that same cycle: 0x7FFF if the MSB of a_q is 0, else 0x8000.
  - v=overflow.
- PADDSB:
  - Carry is forced to 0 into every nibble.
  - Each nibble saturates independently to 0x7 or 0x8 on 4-bit signed overflow.
  - v=OR of per-nibble overflows.
- DONE: done=1 for one cycle. z/v/n register together with the final nibble. Next state IDLE unconditionally. start is ignored in DONE.
- start during CALC/DONE is ignored; latched operands are unaffected.
- Reset values: state=IDLE, ready=1, done=0, result=0x0000, z=0, v=0, n=0, idx=0, carry=0.
- Reset mid-operation aborts with no done pulse. All outputs take their reset values on the next edge.

## Timing
- Start sampled high at edge E0.
- CALC occupies the cycles following edges E0..E3, processing nibbles 0..3.
- done is high in the cycle after edge E4.
- ready returns at E5.
- Latency: 5 cycles start-to-done. Throughput: one operation per 6 cycles.
- result, z, v and n change only at edge E4 or on reset. They are stable from done until the next operation's E4.
- The nibble slice is purely combinational. The only critical path is the slice plus the saturation mux into result_q.

## Configuration
- SERIAL_ADD_PADDSB_EN defined: op=10 performs PADDSB as above.
- Not defined: op=10 executes as 16-bit saturating ADD. No per-nibble saturation logic is built.
- Timing and handshake are identical either way.

## Structure
- Package serial_add_pkg contains:
  - typedef enum op_t {OP_ADD, OP_SUB, OP_PADDSB, OP_RSVD}
  - typedef enum state_t {IDLE, CALC, DONE}
  - constants WORD_W=16, NIB_W=4, SAT_POS16=16'h7FFF, SAT_NEG16=16'h8000, SAT_POS4=4'h7, SAT_NEG4=4'h8
- One sub-module: cla_nibble_slice.
  - Inputs: 4-bit a, 4-bit b, cin.
  - Outputs: 4-bit sum, group gen, group prop.
  - The controller derives carry-out from gen/prop; the slice exposes no separate carry-out.

## Test plan
- ADD 0x1234+0x0F0F: start at cycle 0 → done in cycle 5, result=0x2143, z=0, v=0, n=0; ready=0 during cycles 1–5.
- ADD 0x7FFF+0x0001 → result=0x7FFF, v=1, n=0. Then SUB 0x8000−0x0001 → 0x8000, v=1, n=1.
- SUB 0x0005−0x0005 → result=0x0000, z=1, v=0, n=0.
- PADDSB 0x7381+0x1F8F:
  - With SERIAL_ADD_PADDSB_EN → result=0x7280, v=1.
  - Without it → result=0x7FFF, v=1.
- Reset asserted in cycle 2 of an ADD:
  - done never pulses.
  - result=0x0000 and ready=1 from the next cycle.
  - A new start is accepted immediately.
- start held high with different operands throughout CALC and DONE:
  - Those operands are ignored; the first result is correct.
  - The second operation is accepted at the edge ending cycle 6, with done in cycle 11.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial saturating adder.
// Optional feature macro: SERIAL_ADD_PADDSB_EN (see serial_add16_ctrl.sv).
package serial_add_pkg;

    localparam int WORD_W = 16;
    localparam int NIB_W  = 4;

    localparam logic [WORD_W-1:0] SAT_POS16 = 16'h7FFF;
    localparam logic [WORD_W-1:0] SAT_NEG16 = 16'h8000;
    localparam logic [NIB_W-1:0]  SAT_POS4  = 4'h7;
    localparam logic [NIB_W-1:0]  SAT_NEG4  = 4'h8;

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_SUB    = 2'b01,
        OP_PADDSB = 2'b10,
        OP_RSVD   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Saturation bound chosen by the sign of the first operand.
    function automatic logic [NIB_W-1:0] sat_nib(input logic sign);
        return sign ? SAT_NEG4 : SAT_POS4;
    endfunction

    function automatic logic [WORD_W-1:0] sat_word(input logic sign);
        return sign ? SAT_NEG16 : SAT_POS16;
    endfunction

endpackage

// File: rtl/serial_add16_ctrl_slice.sv
// Purely combinational 4-bit carry-lookahead slice exposing group generate/propagate.
// The consumer forms the nibble carry-out as gen | (prop & cin).
module cla_nibble_slice
    import serial_add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             gen,
    output logic             prop
);

    logic [NIB_W-1:0] g_s;
    logic [NIB_W-1:0] p_s;
    logic [NIB_W-1:0] c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Lookahead carries into each bit position.
    always_comb begin
        c_s[0] = cin;
        c_s[1] = g_s[0] | (p_s[0] & cin);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin);
    end

    assign sum  = p_s ^ c_s;
    assign gen  = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    assign prop = &p_s;

endmodule

// File: rtl/serial_add16_ctrl.sv
// 16-bit saturating ADD/SUB controller reusing one CLA nibble slice over four cycles.
// Define SERIAL_ADD_PADDSB_EN to build per-nibble saturating PADDSB for op=10.
module serial_add16_ctrl
    import serial_add_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              ready,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic              z,
    output logic              v,
    output logic              n
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [1:0]        idx_r;
    logic              carry_r;
    logic [WORD_W-1:0] a_r;
    logic [WORD_W-1:0] b_r;
    logic [WORD_W-1:0] acc_r;
    logic              pv_r;
    logic [WORD_W-1:0] result_r;
    logic              z_r;
    logic              v_r;
    logic              n_r;
    logic              done_r;
    logic              ready_r;

    logic              paddsb_s;
    logic [NIB_W-1:0]  a_nib_s;
    logic [NIB_W-1:0]  b_nib_s;
    logic              cin_s;
    logic [NIB_W-1:0]  sum_s;
    logic              gen_s;
    logic              prop_s;
    logic              cout_s;
    logic              c3_s;
    logic              nib_ovf_s;
    logic [NIB_W-1:0]  nib_val_s;
    logic [WORD_W-1:0] acc_nxt_s;
    logic [WORD_W-1:0] final_s;
    logic              v_final_s;

`ifdef SERIAL_ADD_PADDSB_EN
    logic paddsb_r;

    // Remembers whether the accepted operation is a packed-nibble add.
    always_ff @(posedge clk) begin
        if (rst) begin
            paddsb_r <= 1'b0;
        end else if (state_r == IDLE && start) begin
            paddsb_r <= (op_t'(op) == OP_PADDSB);
        end else begin
            paddsb_r <= paddsb_r;
        end
    end

    assign paddsb_s = paddsb_r;
`else
    assign paddsb_s = 1'b0;
`endif

    assign a_nib_s = a_r[{idx_r, 2'b00} +: NIB_W];
    assign b_nib_s = b_r[{idx_r, 2'b00} +: NIB_W];
    assign cin_s   = paddsb_s ? 1'b0 : carry_r;

    cla_nibble_slice u_slice (
        .a    (a_nib_s),
        .b    (b_nib_s),
        .cin  (cin_s),
        .sum  (sum_s),
        .gen  (gen_s),
        .prop (prop_s)
    );

    // Carry into bit 3 is recovered from the sum bit, so the slice needs no extra output.
    assign cout_s    = gen_s | (prop_s & cin_s);
    assign c3_s      = a_nib_s[3] ^ b_nib_s[3] ^ sum_s[3];
    assign nib_ovf_s = c3_s ^ cout_s;

    // Nibble write-back plus whole-word saturation on the last nibble.
    always_comb begin
        if (paddsb_s && nib_ovf_s) begin
            nib_val_s = sat_nib(a_nib_s[3]);
        end else begin
            nib_val_s = sum_s;
        end
        acc_nxt_s = acc_r;
        acc_nxt_s[{idx_r, 2'b00} +: NIB_W] = nib_val_s;
        if (!paddsb_s && nib_ovf_s) begin
            final_s = sat_word(a_r[WORD_W-1]);
        end else begin
            final_s = acc_nxt_s;
        end
        if (paddsb_s) begin
            v_final_s = pv_r | nib_ovf_s;
        end else begin
            v_final_s = nib_ovf_s;
        end
    end

    // Next-state logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (idx_r == 2'd3) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == IDLE);
            done_r  <= (state_r == CALC) && (idx_r == 2'd3);
        end
    end

    // Operand capture, nibble iteration and final result/flag update.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r    <= 2'd0;
            carry_r  <= 1'b0;
            a_r      <= 16'h0000;
            b_r      <= 16'h0000;
            acc_r    <= 16'h0000;
            pv_r     <= 1'b0;
            result_r <= 16'h0000;
            z_r      <= 1'b0;
            v_r      <= 1'b0;
            n_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= (op_t'(op) == OP_SUB) ? ~b : b;
                        carry_r <= (op_t'(op) == OP_SUB);
                        idx_r   <= 2'd0;
                        acc_r   <= 16'h0000;
                        pv_r    <= 1'b0;
                    end
                end
                CALC: begin
                    acc_r   <= acc_nxt_s;
                    carry_r <= cout_s;
                    idx_r   <= idx_r + 2'd1;
                    pv_r    <= pv_r | nib_ovf_s;
                    if (idx_r == 2'd3) begin
                        result_r <= final_s;
                        z_r      <= (final_s == 16'h0000);
                        v_r      <= v_final_s;
                        n_r      <= final_s[WORD_W-1];
                    end
                end
                DONE: begin
                    idx_r <= 2'd0;
                end
                default: begin
                    idx_r <= 2'd0;
                end
            endcase
        end
    end

    assign ready  = ready_r;
    assign done   = done_r;
    assign result = result_r;
    assign z      = z_r;
    assign v      = v_r;
    assign n      = n_r;

endmodule

// File: tb/tb_serial_add16_ctrl.sv
// Directed self-checking bench for serial_add16_ctrl; outputs sampled on the falling edge.
module tb_serial_add16_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic        z;
    logic        v;
    logic        n;

    int n_checks;
    int n_fail;

    serial_add16_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .z      (z),
        .v      (v),
        .n      (n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller is at a falling edge; start is driven for exactly one cycle (cycle 0).
    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] er,
                          input logic ez, input logic ev, input logic en);
        check_eq({tag, "_ready_idle"}, {15'd0, ready}, 16'd1);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            check_eq({tag, "_ready_busy"}, {15'd0, ready}, 16'd0);
            check_eq({tag, "_done"}, {15'd0, done}, {15'd0, (c == 5)});
        end
        check_eq({tag, "_result"}, result, er);
        check_eq({tag, "_z"}, {15'd0, z}, {15'd0, ez});
        check_eq({tag, "_v"}, {15'd0, v}, {15'd0, ev});
        check_eq({tag, "_n"}, {15'd0, n}, {15'd0, en});
        @(negedge clk);
        check_eq({tag, "_done_low"}, {15'd0, done}, 16'd0);
        check_eq({tag, "_result_hold"}, result, er);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 16'h0000;
        b     = 16'h0000;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", {15'd0, ready}, 16'd1);
        check_eq("rst_done", {15'd0, done}, 16'd0);
        check_eq("rst_result", result, 16'h0000);
        check_eq("rst_flags", {13'd0, z, v, n}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add", 2'b00, 16'h1234, 16'h0F0F, 16'h2143, 1'b0, 1'b0, 1'b0);
        run_op("add_sat", 2'b00, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("sub_sat", 2'b01, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
        run_op("sub_zero", 2'b01, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("rsvd_add", 2'b11, 16'h0100, 16'h00FF, 16'h01FF, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_ADD_PADDSB_EN
        run_op("paddsb", 2'b10, 16'h7381, 16'h1F8F, 16'h7280, 1'b0, 1'b1, 1'b0);
`else
        run_op("paddsb", 2'b10, 16'h7381, 16'h1F8F, 16'h7FFF, 1'b0, 1'b1, 1'b0);
`endif

        // Reset in cycle 2 of an ADD: abort, no done, outputs cleared.
        start = 1'b1;
        op    = 2'b00;
        a     = 16'h0011;
        b     = 16'h0022;
        @(negedge clk);
        start = 1'b0;
        check_eq("abort_c1_done", {15'd0, done}, 16'd0);
        @(negedge clk);
        check_eq("abort_c2_done", {15'd0, done}, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_result", result, 16'h0000);
        check_eq("abort_ready", {15'd0, ready}, 16'd1);
        check_eq("abort_done", {15'd0, done}, 16'd0);
        run_op("post_rst", 2'b00, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);

        // start held high through CALC/DONE with changed operands.
        start = 1'b1;
        op    = 2'b00;
        a     = 16'h1111;
        b     = 16'h2222;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) begin
                op = 2'b01;
                a  = 16'h4444;
                b  = 16'h1000;
            end
            if (c == 7) start = 1'b0;
            check_eq("held_done", {15'd0, done}, {15'd0, (c == 5 || c == 11)});
            check_eq("held_ready", {15'd0, ready}, {15'd0, (c == 6)});
            if (c == 5) check_eq("held_first", result, 16'h3333);
            if (c == 11) check_eq("held_second", result, 16'h3444);
        end
        @(negedge clk);
        check_eq("held_final_ready", {15'd0, ready}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
